// File: rtl/hilo_div_unit.sv
// HI/LO register file with a restoring radix-2 divider. Captures multiply products,
// serves MTHI/MTLO writes, and runs DIV/DIVU over WIDTH+1 cycles while busy.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mult_we,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] rem_q, quo_q, dmag_q, dividend_q;
  logic             quo_neg_q, rem_neg_q, dzero_q;
  logic             busy_q, done_q, dbz_q;

  // Operand magnitudes and result signs, sampled only when start is accepted.
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;

  always_comb begin
    a_neg = div_signed & dividend[WIDTH-1];
    b_neg = div_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
  end

  // One restoring step: shift {rem, quo} left, trial-subtract with a 33-bit compare.
  logic [WIDTH:0]   rem_sh, trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, dmag_q};
    no_borrow = ~trial[WIDTH];
    rem_nx    = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx    = {quo_q[WIDTH-2:0], no_borrow};
  end

  logic [WIDTH-1:0] lo_fix, hi_fix;
  logic             last_iter;

  always_comb begin
    lo_fix    = quo_neg_q ? -quo_q : quo_q;
    hi_fix    = rem_neg_q ? -rem_q : rem_q;
    if (dzero_q) begin
      lo_fix = '1;
      hi_fix = dividend_q;
    end
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dmag_q     <= '0;
      dividend_q <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dzero_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // start wins over any register write issued in the same cycle.
          if (start) begin
            rem_q      <= '0;
            quo_q      <= a_mag;
            dmag_q     <= b_mag;
            dividend_q <= dividend;
            quo_neg_q  <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            dzero_q    <= (divisor == '0);
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end else if (mult_we) begin
            hi_q <= mult_hi;
            lo_q <= mult_lo;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        StRun: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          dbz_q   <= dzero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- HI/LO register file and iterative divider placed directly downstream of the ALU.
- Captures the 64-bit multiply product the ALU presents on hi/out3 when ALUCtr=14.
- Executes 32-bit signed/unsigned division (DIV/DIVU) as a multi-cycle restoring divider. Quotient goes to LO, remainder to HI.
- Supplies MFHI/MFLO read data and accepts MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand / HI / LO width
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- mult_we  input  1  write multiply product into HI/LO
- mult_hi  input  WIDTH  product upper half (ALU hi)
- mult_lo  input  WIDTH  product lower half (ALU out3)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- start  input  1  begin division (single-cycle pulse)
- div_signed  input  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  input  WIDTH  sampled with start
- divisor  input  WIDTH  sampled with start
- busy  output  1  divider active; upstream must stall HI/LO ops
- done  output  1  one-cycle pulse when division result is written
- div_by_zero  output  1  one-cycle pulse coincident with done when divisor was 0
- hi_out  output  WIDTH  HI register
- lo_out  output  WIDTH  LO register

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low: sampled only on a rising clk edge, and the block is in reset while rst_n=0.
- Reset values: hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- Reset mid-division aborts the operation: no HI/LO write, no done pulse.
- hi_out and lo_out are direct register outputs. A write becomes visible the cycle after its enable edge.
- State machine IDLE -> RUN -> FIX -> IDLE.
- IDLE, write priority at each edge: start > mult_we > (mthi, mtlo).
  - mthi and mtlo may be asserted together; both registers are then written with wdata.
  - mult_we writes {HI,LO} = {mult_hi, mult_lo}.
  - If start is accepted in the same cycle as mult_we, mthi or mtlo, those writes are dropped.
- start accepted at edge E0 (IDLE only):
  - Latch operand magnitudes: two's-complement absolute value when div_signed=1, raw value otherwise.
  - Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31] (both 0 when unsigned).
  - Latch the dividend raw value and a zero flag for divisor==0.
  - counter=0, state=RUN. busy=1 from the cycle after E0.
- RUN, one quotient bit per edge, E1..E32:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem (33-bit compare).
  - If no borrow, commit the subtraction and set the quotient LSB to 1.
  - After counter=31, state=FIX.
- FIX (edge E33):
  - Apply sign: LO = sign_q ? -quo : quo; HI = sign_r ? -rem : rem.
  - Divide-by-zero override: LO=32'hFFFFFFFF, HI=raw dividend, div_by_zero=1.
  - done=1 for one cycle, busy=0, state=IDLE.
- Latency: result visible on hi_out/lo_out, with done=1, in the cycle after E33. busy is high for exactly 33 cycles.
- While busy: start, mult_we, mthi and mtlo are ignored (no queueing). hi_out/lo_out hold their pre-division values until the FIX edge.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, div_by_zero=0 (falls out of the magnitude arithmetic).
- start may be accepted in the same cycle done is high (state is IDLE).
- All arithmetic is modulo 2^WIDTH. No exceptions are raised.

Test Plan:
- Reset: hold rst_n=0 for 2 edges after random writes -> hi_out=0, lo_out=0, busy=0, done=0. Also check rst_n=0 mid-RUN (edge E20) -> next cycle busy=0, HI/LO=0, no done pulse ever.
- Multiply capture: mult_we=1, mult_hi=0x00000001, mult_lo=0x00000000 -> next cycle hi_out=0x1, lo_out=0x0. Then mthi=1 and mtlo=1 with wdata=0xDEADBEEF -> both registers = 0xDEADBEEF.
- DIVU 100/7: start with div_signed=0 -> busy high 33 cycles, then done=1, lo_out=14, hi_out=2, div_by_zero=0.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Same operands with DIVU -> lo_out=0x7FFFFFFC, hi_out=0x1.
- Edge cases:
  - 0x1234/0 -> lo_out=0xFFFFFFFF, hi_out=0x1234, div_by_zero pulses with done.
  - DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Busy interlock: during RUN assert mthi (wdata=0x55), mult_we and a second start -> all ignored; final HI/LO equal the division result only; busy length remains 33.
